// File: rtl/perf_halt_monitor.sv
// Hit/miss counters per cache channel plus terminal spin-loop halt detector.
// Optional shadow snapshot of all counters under PERF_HALT_MONITOR_SNAPSHOT_EN.
module perf_halt_monitor #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 32,
    parameter int HALT_THRESH = 10,
    parameter int PC_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [NUM_CH-1:0] ev_valid_i,
    input  logic [NUM_CH-1:0] ev_hit_i,
    input  logic              br_valid_i,
    input  logic [PC_W-1:0]   br_pc_i,
    input  logic [PC_W-1:0]   br_target_i,
    input  logic              mem_busy_i,
    input  logic [2:0]        rd_ch_i,
    input  logic              rd_miss_i,
`ifdef PERF_HALT_MONITOR_SNAPSHOT_EN
    input  logic              snap_i,
`endif
    output logic [CNT_W-1:0]  rd_data_o,
    output logic [NUM_CH-1:0] sat_o,
    output logic              halt_o
);

    localparam int LOOP_W = (HALT_THRESH < 2) ? 1 : $clog2(HALT_THRESH + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [LOOP_W-1:0] LOOP_MAX = LOOP_W'(HALT_THRESH);

    logic [CNT_W-1:0]  hit_cnt  [NUM_CH];
    logic [CNT_W-1:0]  miss_cnt [NUM_CH];
    logic [CNT_W-1:0]  src_hit  [NUM_CH];
    logic [CNT_W-1:0]  src_miss [NUM_CH];
    logic [LOOP_W-1:0] loop_cnt;
    logic [LOOP_W-1:0] loop_next;
    logic [CNT_W-1:0]  rd_sel;
    logic              det;
    logic              mismatch;

    // Event counters; frozen while halted so end-of-run statistics stay put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hit_cnt[c]  <= '0;
                miss_cnt[c] <= '0;
            end
            sat_o <= '0;
        end else if (clear_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hit_cnt[c]  <= '0;
                miss_cnt[c] <= '0;
            end
            sat_o <= '0;
        end else if (!halt_o) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ev_valid_i[c]) begin
                    if (ev_hit_i[c]) begin
                        if (hit_cnt[c] == CNT_MAX) sat_o[c] <= 1'b1;
                        else hit_cnt[c] <= hit_cnt[c] + 1'b1;
                    end else begin
                        if (miss_cnt[c] == CNT_MAX) sat_o[c] <= 1'b1;
                        else miss_cnt[c] <= miss_cnt[c] + 1'b1;
                    end
                end
            end
        end
    end

    assign det      = br_valid_i && (br_pc_i == br_target_i) && !mem_busy_i;
    assign mismatch = br_valid_i && (br_pc_i != br_target_i);

    always_comb begin
        loop_next = loop_cnt;
        if (mismatch)
            loop_next = '0;
        else if (det && loop_cnt != LOOP_MAX)
            loop_next = loop_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loop_cnt <= '0;
            halt_o   <= 1'b0;
        end else if (clear_i) begin
            loop_cnt <= '0;
            halt_o   <= 1'b0;
        end else begin
            loop_cnt <= loop_next;
            halt_o   <= halt_o || (loop_next == LOOP_MAX);
        end
    end

`ifdef PERF_HALT_MONITOR_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow_hit  [NUM_CH];
    logic [CNT_W-1:0] shadow_miss [NUM_CH];

    // Shadows capture pre-edge counters, so a same-cycle clear is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_hit[c]  <= '0;
                shadow_miss[c] <= '0;
            end
        end else if (snap_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_hit[c]  <= hit_cnt[c];
                shadow_miss[c] <= miss_cnt[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            src_hit[c]  = shadow_hit[c];
            src_miss[c] = shadow_miss[c];
        end
    end
`else
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            src_hit[c]  = hit_cnt[c];
            src_miss[c] = miss_cnt[c];
        end
    end
`endif

    // Out-of-range channel selects fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch_i == 3'(c))
                rd_sel = rd_miss_i ? src_miss[c] : src_hit[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_o <= '0;
        else     rd_data_o <= rd_sel;
    end

endmodule

// File: tb/tb_perf_halt_monitor.sv
// Directed test of perf_halt_monitor with CNT_W=4 so saturation is reachable.
module tb_perf_halt_monitor;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;
    localparam int PC_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear_i;
    logic [NUM_CH-1:0] ev_valid_i;
    logic [NUM_CH-1:0] ev_hit_i;
    logic              br_valid_i;
    logic [PC_W-1:0]   br_pc_i;
    logic [PC_W-1:0]   br_target_i;
    logic              mem_busy_i;
    logic [2:0]        rd_ch_i;
    logic              rd_miss_i;
    logic              snap_i;
    logic [CNT_W-1:0]  rd_data_o;
    logic [NUM_CH-1:0] sat_o;
    logic              halt_o;

    int tests_run = 0;
    int tests_failed = 0;

    perf_halt_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .HALT_THRESH(10), .PC_W(PC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear_i(clear_i),
        .ev_valid_i(ev_valid_i),
        .ev_hit_i(ev_hit_i),
        .br_valid_i(br_valid_i),
        .br_pc_i(br_pc_i),
        .br_target_i(br_target_i),
        .mem_busy_i(mem_busy_i),
        .rd_ch_i(rd_ch_i),
        .rd_miss_i(rd_miss_i),
`ifdef PERF_HALT_MONITOR_SNAPSHOT_EN
        .snap_i(snap_i),
`endif
        .rd_data_o(rd_data_o),
        .sat_o(sat_o),
        .halt_o(halt_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ev(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] h);
        ev_valid_i = v;
        ev_hit_i   = h;
    endtask

    task automatic set_br(input logic v, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt);
        br_valid_i  = v;
        br_pc_i     = pc;
        br_target_i = tgt;
    endtask

    initial begin
        rst = 1'b1; clear_i = 1'b0; snap_i = 1'b0;
        set_ev('0, '0); set_br(1'b0, '0, '0);
        mem_busy_i = 1'b0; rd_ch_i = 3'd0; rd_miss_i = 1'b0;
        #2;
        check("reset_rd",   32'(rd_data_o), 32'd0);
        check("reset_sat",  32'(sat_o),     32'd0);
        check("reset_halt", 32'(halt_o),    32'd0);
        #10;
        rst = 1'b0;

        // Channel 1: 5 hits, 3 misses
        set_ev(2'b10, 2'b10); tick(5);
        set_ev(2'b10, 2'b00); tick(3);
        set_ev(2'b00, 2'b00);
        rd_ch_i = 3'd1; rd_miss_i = 1'b0; tick(1);
        check("ch1_hit", 32'(rd_data_o), 32'd5);
        rd_miss_i = 1'b1; #1;
        check("rd_latency", 32'(rd_data_o), 32'd5);
        tick(1);
        check("ch1_miss", 32'(rd_data_o), 32'd3);
        rd_ch_i = 3'd0; rd_miss_i = 1'b0; tick(1);
        check("ch0_hit_zero", 32'(rd_data_o), 32'd0);
        rd_ch_i = 3'd5; tick(1);
        check("ch_out_of_range", 32'(rd_data_o), 32'd0);

        // Saturation on channel 0
        rd_ch_i = 3'd0; rd_miss_i = 1'b0;
        set_ev(2'b01, 2'b01); tick(15);
        check("sat_before_drop", 32'(sat_o), 32'd0);
        tick(2);
        set_ev(2'b00, 2'b00); tick(1);
        check("ch0_saturated", 32'(rd_data_o), 32'd15);
        check("sat_flag", 32'(sat_o), 32'b01);

        // Clear overrides a same-cycle hit; readout still reflects pre-edge state
        clear_i = 1'b1; set_ev(2'b01, 2'b01); tick(1);
        clear_i = 1'b0; set_ev(2'b00, 2'b00);
        check("clear_rd_preedge", 32'(rd_data_o), 32'd15);
        check("clear_sat", 32'(sat_o), 32'd0);
        tick(1);
        check("clear_ch0", 32'(rd_data_o), 32'd0);

        // Halt after 10 self-loop detections, counters frozen afterwards
        set_ev(2'b01, 2'b01); tick(2); set_ev(2'b00, 2'b00);
        set_br(1'b1, 32'h60, 32'h60); tick(9);
        check("halt_at_9", 32'(halt_o), 32'd0);
        tick(1);
        check("halt_at_10", 32'(halt_o), 32'd1);
        set_br(1'b0, '0, '0);
        set_ev(2'b01, 2'b01); tick(3); set_ev(2'b00, 2'b00);
        tick(1);
        check("frozen_ch0", 32'(rd_data_o), 32'd2);
        check("halt_sticky", 32'(halt_o), 32'd1);
        clear_i = 1'b1; tick(1); clear_i = 1'b0;
        check("clear_halt", 32'(halt_o), 32'd0);

        // Non-self branch restarts the loop count
        set_br(1'b1, 32'h60, 32'h60); tick(6);
        set_br(1'b1, 32'h60, 32'h64); tick(1);
        set_br(1'b1, 32'h60, 32'h60); tick(9);
        check("halt_after_reset_9", 32'(halt_o), 32'd0);
        tick(1);
        check("halt_after_reset_10", 32'(halt_o), 32'd1);
        set_br(1'b0, '0, '0);
        clear_i = 1'b1; tick(1); clear_i = 1'b0;

        // Self-loops while memory busy hold the count
        set_br(1'b1, 32'h60, 32'h60); tick(5);
        mem_busy_i = 1'b1; tick(20);
        check("busy_no_halt", 32'(halt_o), 32'd0);
        mem_busy_i = 1'b0; tick(4);
        check("busy_resume_9", 32'(halt_o), 32'd0);
        tick(1);
        check("busy_resume_10", 32'(halt_o), 32'd1);
        set_br(1'b0, '0, '0);
        clear_i = 1'b1; tick(1); clear_i = 1'b0;

        // Asynchronous reset mid-operation
        set_ev(2'b10, 2'b10); tick(16); set_ev(2'b00, 2'b00);
        rd_ch_i = 3'd1; rd_miss_i = 1'b0; tick(1);
        check("ch1_sat_rd", 32'(rd_data_o), 32'd15);
        check("ch1_sat_flag", 32'(sat_o), 32'b10);
        set_br(1'b1, 32'h60, 32'h60); tick(3);
        #2 rst = 1'b1;
        #1;
        check("async_rd", 32'(rd_data_o), 32'd0);
        check("async_sat", 32'(sat_o), 32'd0);
        set_br(1'b0, '0, '0);
        rst = 1'b0;
        tick(1);
        check("post_rst_ch1", 32'(rd_data_o), 32'd0);
        set_br(1'b1, 32'h60, 32'h60); tick(9);
        check("post_rst_loop_9", 32'(halt_o), 32'd0);
        tick(1);
        check("post_rst_loop_10", 32'(halt_o), 32'd1);
        set_br(1'b0, '0, '0);
        clear_i = 1'b1; tick(1); clear_i = 1'b0;

`ifdef PERF_HALT_MONITOR_SNAPSHOT_EN
        rd_ch_i = 3'd0; rd_miss_i = 1'b0;
        set_ev(2'b01, 2'b01); tick(7); set_ev(2'b00, 2'b00);
        snap_i = 1'b1; tick(1); snap_i = 1'b0;
        set_ev(2'b01, 2'b01); tick(4); set_ev(2'b00, 2'b00);
        tick(1);
        check("snapshot_ch0", 32'(rd_data_o), 32'd7);
        snap_i = 1'b1; clear_i = 1'b1; tick(1); snap_i = 1'b0; clear_i = 1'b0;
        tick(1);
        check("snapshot_preclear", 32'(rd_data_o), 32'd11);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/perf_halt_monitor.md
Name: perf_halt_monitor

Overview:
- Synthesizable performance and halt monitor for the mp4 pipeline.
- Counts hit and miss events on NUM_CH cache channels (e.g. icache, dcache, L2) with saturating counters, read through a registered select port.
- Detects a self-looping branch, i.e. the program's terminal spin loop, and raises a sticky halt.
- Sits beside the CPU core and memory bus, fed from EX-stage branch info and the cache controllers' idle-state lookup strobes.

Parameters:
- NUM_CH, 2, number of cache channels monitored (1..8).
- CNT_W, 32, width of each hit/miss counter.
- HALT_THRESH, 10, consecutive self-loop detections before halt asserts (>=1).
- PC_W, 32, width of branch PC/target compare.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- clear_i  in  1  synchronous clear of counters, sat flags, loop count and halt.
- ev_valid_i  in  NUM_CH  per-channel lookup event strobe (one event per cycle per channel).
- ev_hit_i  in  NUM_CH  per-channel: 1 = hit, 0 = miss; qualified by ev_valid_i.
- br_valid_i  in  1  resolved branch/jump present in EX this cycle.
- br_pc_i  in  PC_W  PC of that branch.
- br_target_i  in  PC_W  next PC selected by the PC mux.
- mem_busy_i  in  1  physical memory read or write in progress.
- rd_ch_i  in  3  channel select for readout.
- rd_miss_i  in  1  0 = read hit counter, 1 = read miss counter.
- rd_data_o  out  CNT_W  selected counter value.
- sat_o  out  NUM_CH  sticky: a counter of that channel saturated.
- halt_o  out  1  sticky halt request.

Behaviour:
- Reset (async, rst=1):
  - All counters, sat_o, halt_o, rd_data_o and the loop count are 0.
  - Deassertion is taken synchronously by the first clk edge.
- Event counting, per channel c, on each clk edge with halt_o=0 and clear_i=0:
  - ev_valid_i[c] & ev_hit_i[c]: hit_cnt[c] += 1.
  - ev_valid_i[c] & ~ev_hit_i[c]: miss_cnt[c] += 1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - The event that is dropped at saturation sets sat_o[c].
- Freeze: while halt_o=1, counters hold their values so end-of-run statistics stay stable.
- Loop detection:
  - det = br_valid_i & (br_pc_i == br_target_i) & ~mem_busy_i.
  - det=1: loop_cnt increments, saturating at HALT_THRESH.
  - br_valid_i=1 with br_pc_i != br_target_i: loop_cnt resets to 0, whatever mem_busy_i is.
  - Otherwise (no branch, or self-loop during mem_busy_i): loop_cnt holds.
  - halt_o rises on the clk edge where loop_cnt becomes HALT_THRESH.
  - halt_o stays 1 until clear_i or rst.
- Readout:
  - rd_data_o is registered, 1-cycle latency: the value reflects the counter state before the edge that samples rd_ch_i/rd_miss_i.
  - rd_ch_i >= NUM_CH returns 0.
- Clear:
  - clear_i=1 zeroes counters, sat_o, loop_cnt and halt_o on the next edge.
  - It overrides same-cycle events and detections.
  - rd_data_o is not cleared; it updates normally from pre-edge state.
- Simultaneous events on different channels are independent, with no arbitration.

Optional Feature:
- Macro: PERF_HALT_MONITOR_SNAPSHOT_EN.
- With the macro defined:
  - Adds input snap_i (1 bit).
  - On an edge with snap_i=1, all counters copy into shadow registers.
  - rd_data_o then reads shadow registers instead of live counters.
  - Shadows reset to 0 on rst. clear_i does not alter them.
  - snap_i and clear_i together: the shadow captures the pre-clear values.
- Without the macro: no snap_i port, no shadow registers; rd_data_o reads live counters.

Test Plan:
- Reset then 5 ev_valid_i[1] hits and 3 misses, rd_ch_i=1 -> rd_data_o=5 with rd_miss_i=0 and 3 with rd_miss_i=1, each one cycle after select; channel 0 reads 0.
- CNT_W=4: 17 consecutive hits on ch0 -> hit counter 15, sat_o=2'b01, no wrap to 0.
- Self-loop br_pc=br_target=0x60 every cycle, mem idle -> halt_o=1 on the 10th detection edge; later hits on ch0 leave counters unchanged.
- 6 self-loop detections, then one branch with pc 0x60 and target 0x64, then 9 detections -> no halt. One more detection -> halt_o=1.
- Self-loop with mem_busy_i=1 for 20 cycles -> loop_cnt unchanged, halt_o=0. Assert rst mid-count -> all outputs 0 immediately, without waiting for a clk edge.
- clear_i and an ev_valid_i[0] hit in the same cycle -> counter 0 after the edge, halt_o cleared. With SNAPSHOT_EN: snap_i at count 7, then 4 more hits -> rd_data_o=7.
